// File: rtl/carfield_addr_guard.sv
// carfield_addr_guard: address-decoding request guard.
// Decodes each upstream request against six base/size regions. A hit is
// forwarded downstream combinationally with its region index. A miss is
// accepted, outstanding traffic is drained, and then a local error response
// is returned. Forwarding is held off while the outstanding counter is at
// its limit, or while it is non-zero and the new request targets a
// different region from the previous forward.
//
// Ports
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   req_valid_i/req_ready_o          upstream request handshake
//   req_addr_i, req_write_i          upstream request payload
//   mst_valid_o/mst_ready_i          forwarded request handshake
//   mst_addr_o, mst_write_o          forwarded payload
//   mst_sel_o                        decoded region index
//   mst_rsp_valid_i/mst_rsp_ready_o  downstream response handshake
//   mst_rsp_err_i                    downstream response error flag
//   rsp_valid_o/rsp_ready_i          upstream response handshake
//   rsp_err_o                        upstream response error flag
//   busy_o                           outstanding traffic or error in progress
module carfield_addr_guard #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned MaxTxn = 8,
  parameter logic [5:0] RegionEnable = 6'b111111,
  parameter logic [5:0][AddrWidth-1:0] RegionBase = {
    AddrWidth'(32'h4000_0000),  // 5 mailbox
    AddrWidth'(32'h5000_0000),  // 4 pulp
    AddrWidth'(32'h5100_0000),  // 3 spatz
    AddrWidth'(32'h2000_1000),  // 2 periph
    AddrWidth'(32'h6000_0000),  // 1 safety
    AddrWidth'(32'h7800_0000)   // 0 L2
  },
  parameter logic [5:0][AddrWidth-1:0] RegionSize = {
    AddrWidth'(32'h0000_1000),
    AddrWidth'(32'h0080_0000),
    AddrWidth'(32'h0080_0000),
    AddrWidth'(32'h0000_9000),
    AddrWidth'(32'h0080_0000),
    AddrWidth'(32'h0020_0000)
  }
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  output logic                 mst_valid_o,
  input  logic                 mst_ready_i,
  output logic [AddrWidth-1:0] mst_addr_o,
  output logic                 mst_write_o,
  output logic [2:0]           mst_sel_o,
  input  logic                 mst_rsp_valid_i,
  output logic                 mst_rsp_ready_o,
  input  logic                 mst_rsp_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_err_o,
  output logic                 busy_o
);

  localparam int unsigned NumRegions = 6;
  localparam int unsigned SelWidth   = 3;
  localparam int unsigned CntWidth   = $clog2(MaxTxn);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxn - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ERR_DRAIN = 2'd1,
    ERR_RSP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic [SelWidth-1:0]   last_sel_q, last_sel_d;

  logic                  hit;
  logic [SelWidth-1:0]   sel;
  logic                  stall;
  logic                  mst_hs;
  logic                  rsp_hs;

  // Region decode; scanning from the top down lets the lowest index win.
  // The offset compare avoids overflow of base+size at the top of the map.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int r = NumRegions - 1; r >= 0; r--) begin
      if (RegionEnable[r] && (RegionSize[r] != '0) &&
          (req_addr_i >= RegionBase[r]) &&
          ((req_addr_i - RegionBase[r]) < RegionSize[r])) begin
        hit = 1'b1;
        sel = SelWidth'(r);
      end
    end
  end

  // Hold off at the counter limit, or when switching regions with traffic
  // still outstanding (responses must come back in order).
  assign stall = (count_q == CntMax) ||
                 ((count_q != '0) && (sel != last_sel_q));

  assign mst_addr_o  = req_addr_i;
  assign mst_write_o = req_write_i;
  assign mst_sel_o   = sel;
  assign busy_o      = (count_q != '0) || (state_q != IDLE);

  // Next-state and handshake outputs.
  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    mst_valid_o     = 1'b0;
    mst_rsp_ready_o = rsp_ready_i;
    rsp_valid_o     = mst_rsp_valid_i;
    rsp_err_o       = mst_rsp_err_i;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (!stall) begin
            mst_valid_o = req_valid_i;
            req_ready_o = mst_ready_i;
          end
        end else if (req_valid_i) begin
          // Swallow the miss; its error response comes after the drain.
          req_ready_o = 1'b1;
          state_d     = ERR_DRAIN;
        end
      end
      ERR_DRAIN: begin
        if (count_q == '0) state_d = ERR_RSP;
      end
      ERR_RSP: begin
        rsp_valid_o     = 1'b1;
        rsp_err_o       = 1'b1;
        mst_rsp_ready_o = 1'b0;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding counter and last forwarded region.
  always_comb begin
    mst_hs     = mst_valid_o && mst_ready_i;
    rsp_hs     = mst_rsp_valid_i && mst_rsp_ready_o;
    count_d    = count_q;
    last_sel_d = last_sel_q;
    if (mst_hs && !rsp_hs && (count_q != CntMax)) begin
      count_d = count_q + CntWidth'(1);
    end else if (!mst_hs && rsp_hs && (count_q != '0)) begin
      count_d = count_q - CntWidth'(1);
    end
    if (mst_hs) last_sel_d = sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      last_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      last_sel_q <= last_sel_d;
    end
  end

endmodule

// File: tb/tb_carfield_addr_guard.sv
// Directed bench for carfield_addr_guard. Expected forwards and responses are
// queued as stimulus is issued; a monitor compares them at each handshake.
module tb_carfield_addr_guard;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [63:0] req_addr_i;
  logic        mst_valid_o, mst_ready_i, mst_write_o;
  logic [63:0] mst_addr_o;
  logic [2:0]  mst_sel_o;
  logic        mst_rsp_valid_i, mst_rsp_ready_o, mst_rsp_err_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;

  // Second instance with region 0 disabled.
  logic        b_rst_ni;
  logic        b_req_valid, b_req_ready;
  logic [63:0] b_req_addr;
  logic        b_mst_valid, b_mst_write;
  logic [63:0] b_mst_addr;
  logic [2:0]  b_mst_sel;
  logic        b_mst_rsp_valid, b_mst_rsp_ready;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [2:0]  sel;
    logic [63:0] addr;
    logic        wr;
  } mst_exp_t;

  mst_exp_t exp_mst[$];
  logic     exp_rsp[$];

  always #5 clk = ~clk;

  carfield_addr_guard u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_write_i     (req_write_i),
    .mst_valid_o     (mst_valid_o),
    .mst_ready_i     (mst_ready_i),
    .mst_addr_o      (mst_addr_o),
    .mst_write_o     (mst_write_o),
    .mst_sel_o       (mst_sel_o),
    .mst_rsp_valid_i (mst_rsp_valid_i),
    .mst_rsp_ready_o (mst_rsp_ready_o),
    .mst_rsp_err_i   (mst_rsp_err_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_err_o       (rsp_err_o),
    .busy_o          (busy_o)
  );

  carfield_addr_guard #(.RegionEnable(6'b111110)) u_dut_noreg0 (
    .clk_i           (clk),
    .rst_ni          (b_rst_ni),
    .req_valid_i     (b_req_valid),
    .req_ready_o     (b_req_ready),
    .req_addr_i      (b_req_addr),
    .req_write_i     (1'b0),
    .mst_valid_o     (b_mst_valid),
    .mst_ready_i     (1'b1),
    .mst_addr_o      (b_mst_addr),
    .mst_write_o     (b_mst_write),
    .mst_sel_o       (b_mst_sel),
    .mst_rsp_valid_i (b_mst_rsp_valid),
    .mst_rsp_ready_o (b_mst_rsp_ready),
    .mst_rsp_err_i   (1'b0),
    .rsp_valid_o     (b_rsp_valid),
    .rsp_ready_i     (b_rsp_ready),
    .rsp_err_o       (b_rsp_err),
    .busy_o          (b_busy)
  );

  function automatic void rec(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] req);
    rec(act === req, name, act, req);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_mst(input logic [2:0] s, input logic [63:0] a);
    mst_exp_t e;
    e.sel  = s;
    e.addr = a;
    e.wr   = req_write_i;
    exp_mst.push_back(e);
  endtask

  // Scoreboard monitor: compares at every downstream and upstream handshake.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (mst_valid_o && mst_ready_i) begin
        if (exp_mst.size() == 0) begin
          rec(1'b0, "mst_unexpected_fwd", mst_addr_o, 64'h0);
        end else begin
          mst_exp_t e;
          e = exp_mst.pop_front();
          chk("mst_sel", 64'(mst_sel_o), 64'(e.sel));
          chk("mst_addr", mst_addr_o, e.addr);
          chk("mst_write", 64'(mst_write_o), 64'(e.wr));
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp.size() == 0) begin
          rec(1'b0, "rsp_unexpected", 64'(rsp_err_o), 64'h0);
        end else begin
          logic e_err;
          e_err = exp_rsp.pop_front();
          chk("rsp_err", 64'(rsp_err_o), 64'(e_err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; b_rst_ni = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
    mst_ready_i = 1'b0; mst_rsp_valid_i = 1'b0; mst_rsp_err_i = 1'b0;
    rsp_ready_i = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_mst_rsp_valid = 1'b0; b_rsp_ready = 1'b0;
    repeat (2) cyc();
    sample();
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_req_ready", 64'(req_ready_o), 64'h0);
    chk("rst_mst_valid", 64'(mst_valid_o), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    cyc();
    rst_ni = 1'b1; b_rst_ni = 1'b1;

    // Single forwarded read and its response.
    req_valid_i = 1'b1; req_addr_i = 64'h7800_0010; mst_ready_i = 1'b1;
    push_mst(3'd0, req_addr_i);
    sample();
    chk("fwd_mst_valid", 64'(mst_valid_o), 64'h1);
    chk("fwd_req_ready", 64'(req_ready_o), 64'h1);
    cyc(); req_valid_i = 1'b0;
    sample(); chk("fwd_busy_cnt1", 64'(busy_o), 64'h1);
    cyc(); mst_rsp_valid_i = 1'b1; mst_rsp_err_i = 1'b0; rsp_ready_i = 1'b1;
    exp_rsp.push_back(1'b0);
    sample(); chk("fwd_rsp_valid", 64'(rsp_valid_o), 64'h1);
    cyc(); mst_rsp_valid_i = 1'b0;
    sample(); chk("fwd_idle_busy", 64'(busy_o), 64'h0);

    // Miss with nothing outstanding; error response held while not ready.
    cyc(); req_valid_i = 1'b1; req_addr_i = 64'h3000_0000;
    exp_rsp.push_back(1'b1);
    sample();
    chk("miss_accept", 64'(req_ready_o), 64'h1);
    chk("miss_no_fwd", 64'(mst_valid_o), 64'h0);
    cyc(); req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    sample(); chk("miss_drain_no_rsp", 64'(rsp_valid_o), 64'h0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("miss_rsp_hold_valid", 64'(rsp_valid_o), 64'h1);
      chk("miss_rsp_hold_err", 64'(rsp_err_o), 64'h1);
      cyc();
    end
    rsp_ready_i = 1'b1;
    sample(); cyc();
    sample(); chk("miss_back_idle", 64'(busy_o), 64'h0);

    // Region switch waits for outstanding traffic to drain.
    cyc(); req_valid_i = 1'b1; req_addr_i = 64'h5100_0000;
    push_mst(3'd3, req_addr_i);
    sample(); cyc();
    req_addr_i = 64'h5100_0100; req_write_i = 1'b1;
    push_mst(3'd3, req_addr_i);
    sample(); cyc();
    req_addr_i = 64'h5000_0000; req_write_i = 1'b0;
    sample();
    chk("switch_stall_valid", 64'(mst_valid_o), 64'h0);
    chk("switch_stall_ready", 64'(req_ready_o), 64'h0);
    cyc(); mst_rsp_valid_i = 1'b1; exp_rsp.push_back(1'b0);
    sample(); chk("switch_stall_cnt2", 64'(mst_valid_o), 64'h0);
    cyc(); exp_rsp.push_back(1'b0);
    sample(); chk("switch_stall_cnt1", 64'(mst_valid_o), 64'h0);
    cyc(); mst_rsp_valid_i = 1'b0;
    push_mst(3'd4, req_addr_i);
    sample(); chk("switch_fwd_valid", 64'(mst_valid_o), 64'h1);
    cyc(); req_valid_i = 1'b0; mst_rsp_valid_i = 1'b1; exp_rsp.push_back(1'b0);
    sample(); cyc(); mst_rsp_valid_i = 1'b0;
    sample(); chk("switch_idle_busy", 64'(busy_o), 64'h0);

    // Fill to the counter limit, then exercise simultaneous handshakes.
    cyc(); req_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_addr_i = 64'h7800_0000 + 64'(i * 8);
      push_mst(3'd0, req_addr_i);
      sample(); cyc();
    end
    req_addr_i = 64'h7800_0100;
    sample();
    chk("full_stall_valid", 64'(mst_valid_o), 64'h0);
    chk("full_stall_ready", 64'(req_ready_o), 64'h0);
    cyc(); mst_rsp_valid_i = 1'b1; exp_rsp.push_back(1'b0);
    sample(); chk("full_stall_with_rsp", 64'(mst_valid_o), 64'h0);
    cyc(); exp_rsp.push_back(1'b0); push_mst(3'd0, req_addr_i);
    sample(); chk("full_fwd_and_rsp", 64'(mst_valid_o), 64'h1);
    cyc(); mst_rsp_valid_i = 1'b0; req_addr_i = 64'h7800_0108;
    push_mst(3'd0, req_addr_i);
    sample(); chk("full_refill", 64'(mst_valid_o), 64'h1);
    cyc(); req_addr_i = 64'h7800_0110;
    sample(); chk("full_stall_again", 64'(mst_valid_o), 64'h0);
    cyc(); req_valid_i = 1'b0; mst_rsp_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_rsp.push_back(1'b0);
      sample(); cyc();
    end
    mst_rsp_valid_i = 1'b0;
    sample(); chk("full_drained_busy", 64'(busy_o), 64'h0);

    // Miss with two outstanding: error response only after both return.
    cyc(); req_valid_i = 1'b1; req_addr_i = 64'h6000_0000;
    push_mst(3'd1, req_addr_i);
    sample(); cyc();
    req_addr_i = 64'h6000_0040; push_mst(3'd1, req_addr_i);
    sample(); cyc();
    req_addr_i = 64'h0000_0000;
    sample();
    chk("drain_miss_accept", 64'(req_ready_o), 64'h1);
    chk("drain_miss_no_fwd", 64'(mst_valid_o), 64'h0);
    cyc(); req_addr_i = 64'h6000_0080;
    sample();
    chk("drain_block_ready", 64'(req_ready_o), 64'h0);
    chk("drain_block_valid", 64'(mst_valid_o), 64'h0);
    cyc(); req_valid_i = 1'b0; mst_rsp_valid_i = 1'b1; exp_rsp.push_back(1'b0);
    sample(); cyc(); exp_rsp.push_back(1'b0);
    sample(); cyc(); mst_rsp_valid_i = 1'b0; exp_rsp.push_back(1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (exp_rsp.size() == 0) break;
    end
    rec(exp_rsp.size() == 0, "drain_err_rsp_timeout", 64'(exp_rsp.size()), 64'h0);
    sample(); chk("drain_idle_busy", 64'(busy_o), 64'h0);

    // Disabled region misses; reset during the error response clears it.
    cyc(); b_req_valid = 1'b1; b_req_addr = 64'h7800_0000;
    sample();
    chk("noreg0_accept", 64'(b_req_ready), 64'h1);
    chk("noreg0_no_fwd", 64'(b_mst_valid), 64'h0);
    cyc(); b_req_valid = 1'b0;
    cyc();
    sample();
    chk("noreg0_err_valid", 64'(b_rsp_valid), 64'h1);
    chk("noreg0_err_flag", 64'(b_rsp_err), 64'h1);
    cyc(); b_rst_ni = 1'b0;
    cyc();
    sample();
    chk("noreg0_rst_rsp_valid", 64'(b_rsp_valid), 64'h0);
    chk("noreg0_rst_busy", 64'(b_busy), 64'h0);
    cyc(); b_mst_rsp_valid = 1'b1;
    sample(); chk("noreg0_rst_passthru", 64'(b_rsp_valid), 64'h1);
    cyc(); b_mst_rsp_valid = 1'b0; b_rst_ni = 1'b1;

    cyc();
    rec(exp_mst.size() == 0, "mst_queue_empty", 64'(exp_mst.size()), 64'h0);
    rec(exp_rsp.size() == 0, "rsp_queue_empty", 64'(exp_rsp.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
